// File: rtl/writeback_stage_if.sv
// MEM->WB bundle: instruction/control/data from the MEM stage and the register-file write port back to ID.
// Latency: none (wires only).
// Backpressure: oStall is carried back to the MEM stage, which must hold its outputs while it is high.
interface writeback_stage_if #(
    parameter int CNT_W = 32
);
    // MEM stage -> write-back
    logic             iValid;
    logic [1:0]       iSig_WB;        // [1] MemtoReg, [0] RegWrite
    logic [31:0]      iALUResult;
    logic [4:0]       iWriteReg;
    logic [31:0]      iMemData;
    logic             iMemDataValid;
    logic             iFlush;

    // write-back -> ID register file / upstream
    logic             oSig_RegWrite;
    logic [4:0]       oWriteReg;
    logic [31:0]      oWriteData2Reg;
    logic             oStall;
    logic             oMemErr;
    logic [CNT_W-1:0] oRetired;

    modport master (
        output iValid, iSig_WB, iALUResult, iWriteReg, iMemData, iMemDataValid, iFlush,
        input  oSig_RegWrite, oWriteReg, oWriteData2Reg, oStall, oMemErr, oRetired
    );

    modport slave (
        input  iValid, iSig_WB, iALUResult, iWriteReg, iMemData, iMemDataValid, iFlush,
        output oSig_RegWrite, oWriteReg, oWriteData2Reg, oStall, oMemErr, oRetired
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with write-back select; drives the ID register-file write port.
// Latency: write pulse 1 cycle after accept (or 1 cycle after load data arrives while waiting).
// Backpressure: oStall (registered state only) holds upstream while a load is outstanding.
//
// Ports: clk / rstn (synchronous, active-high reset) plus the slave side of
// writeback_stage_if: instruction inputs from MEM, load data handshake, flush,
// and the register-file write port, stall, sticky timeout error and retire count.
module writeback_stage #(
    parameter int MEM_TIMEOUT = 15,   // 1..255
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rstn,
    writeback_stage_if.slave   wb
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           nextState;

    logic [7:0]       waitCnt;
    logic             heldRegWrite;
    logic [4:0]       heldWriteReg;

    logic             writeEnQ;
    logic [4:0]       writeRegQ;
    logic [31:0]      writeDataQ;
    logic             memErrQ;
    logic [CNT_W-1:0] retiredQ;

    logic             accept;
    logic             isLoad;
    logic             timeoutHit;

    // next-cycle controls from the output decode
    logic             latchLoad;
    logic             outUpd;
    logic             outWe;
    logic [4:0]       outReg;
    logic [31:0]      outData;
    logic             retire;
    logic             setErr;
    logic             waitClr;
    logic             waitInc;

    assign accept     = wb.iValid && !wb.iFlush;
    assign isLoad     = wb.iSig_WB[1];
    // The cycle that would make the wait count reach MEM_TIMEOUT ends the wait.
    assign timeoutHit = (waitCnt == 8'(MEM_TIMEOUT - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= S_RUN;
        end else begin
            state <= nextState;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        nextState = state;
        case (state)
            S_RUN: begin
                if (accept && isLoad && !wb.iMemDataValid) begin
                    nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wb.iFlush || wb.iMemDataValid || timeoutHit) begin
                    nextState = S_RUN;
                end
            end
            default: nextState = S_RUN;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        latchLoad = 1'b0;
        outUpd    = 1'b0;
        outWe     = 1'b0;
        outReg    = writeRegQ;
        outData   = writeDataQ;
        retire    = 1'b0;
        setErr    = 1'b0;
        waitClr   = 1'b0;
        waitInc   = 1'b0;
        case (state)
            S_RUN: begin
                if (accept) begin
                    if (isLoad && !wb.iMemDataValid) begin
                        latchLoad = 1'b1;
                        waitClr   = 1'b1;
                    end else begin
                        outUpd  = 1'b1;
                        outReg  = wb.iWriteReg;
                        outData = isLoad ? wb.iMemData : wb.iALUResult;
                        outWe   = wb.iSig_WB[0] && (wb.iWriteReg != 5'd0);
                        retire  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Flush wins: a same-cycle data beat is dropped with the instruction.
                if (wb.iFlush) begin
                    outWe = 1'b0;
                end else if (wb.iMemDataValid) begin
                    outUpd  = 1'b1;
                    outReg  = heldWriteReg;
                    outData = wb.iMemData;
                    outWe   = heldRegWrite && (heldWriteReg != 5'd0);
                    retire  = 1'b1;
                end else if (timeoutHit) begin
                    // Abandoned load still counts as retired, but never writes.
                    setErr = 1'b1;
                    retire = 1'b1;
                end else begin
                    waitInc = 1'b1;
                end
            end
            default: outWe = 1'b0;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            waitCnt      <= '0;
            heldRegWrite <= 1'b0;
            heldWriteReg <= '0;
            writeEnQ     <= 1'b0;
            writeRegQ    <= '0;
            writeDataQ   <= '0;
            memErrQ      <= 1'b0;
            retiredQ     <= '0;
        end else begin
            writeEnQ <= outWe;
            if (outUpd) begin
                writeRegQ  <= outReg;
                writeDataQ <= outData;
            end
            if (latchLoad) begin
                heldRegWrite <= wb.iSig_WB[0];
                heldWriteReg <= wb.iWriteReg;
            end
            if (waitClr) begin
                waitCnt <= '0;
            end else if (waitInc) begin
                waitCnt <= waitCnt + 8'd1;
            end
            if (setErr) begin
                memErrQ <= 1'b1;
            end
            if (retire) begin
                retiredQ <= retiredQ + 1'b1;
            end
        end
    end

    assign wb.oSig_RegWrite  = writeEnQ;
    assign wb.oWriteReg      = writeRegQ;
    assign wb.oWriteData2Reg = writeDataQ;
    assign wb.oStall         = (state == S_WAIT);
    assign wb.oMemErr        = memErrQ;
    assign wb.oRetired       = retiredQ;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
// Inputs are driven between edges; outputs are sampled 1 time unit after the rising edge.
module tb_writeback_stage;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 32;

    logic clk;
    logic rstn;

    writeback_stage_if #(.CNT_W(CNT_W)) bus ();

    writeback_stage #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .wb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int numChecks;
    int numErrors;

    // ---------------- reference model ----------------
    // A load is either outstanding (with the register it targets and how many
    // data-less cycles it has waited) or not; everything else is the visible
    // register-file write port and two counters.
    bit               loadPending;
    bit               pendWe;
    bit [4:0]         pendReg;
    int               waitedCycles;
    bit               expWe;
    bit [4:0]         expReg;
    bit [31:0]        expData;
    bit               expErr;
    bit [CNT_W-1:0]   expRetired;
    int               stallCycles;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Record that an instruction completed, optionally writing reg/data.
    task automatic retireInstr(input bit we, input bit [4:0] r, input bit [31:0] d);
        expReg     = r;
        expData    = d;
        expWe      = we && (r != 5'd0);
        expRetired = expRetired + 1'b1;
    endtask

    task automatic modelStep();
        expWe = 1'b0;
        if (rstn) begin
            loadPending  = 1'b0;
            waitedCycles = 0;
            expReg       = '0;
            expData      = '0;
            expErr       = 1'b0;
            expRetired   = '0;
        end else if (!loadPending) begin
            if (bus.iValid && !bus.iFlush) begin
                if (!bus.iSig_WB[1]) begin
                    retireInstr(bus.iSig_WB[0], bus.iWriteReg, bus.iALUResult);
                end else if (bus.iMemDataValid) begin
                    retireInstr(bus.iSig_WB[0], bus.iWriteReg, bus.iMemData);
                end else begin
                    loadPending  = 1'b1;
                    pendWe       = bus.iSig_WB[0];
                    pendReg      = bus.iWriteReg;
                    waitedCycles = 0;
                end
            end
        end else begin
            if (bus.iFlush) begin
                loadPending = 1'b0;
            end else if (bus.iMemDataValid) begin
                retireInstr(pendWe, pendReg, bus.iMemData);
                loadPending = 1'b0;
            end else begin
                waitedCycles++;
                if (waitedCycles == MEM_TIMEOUT) begin
                    expErr      = 1'b1;
                    expRetired  = expRetired + 1'b1;
                    loadPending = 1'b0;
                end
            end
        end
    endtask

    // Advance one clock with the inputs currently applied, then compare.
    task automatic cycle();
        modelStep();
        @(posedge clk);
        #1;
        if (bus.oStall === 1'b1) stallCycles++;
        checkVal("oSig_RegWrite",  64'(bus.oSig_RegWrite),  64'(expWe));
        checkVal("oWriteReg",      64'(bus.oWriteReg),      64'(expReg));
        checkVal("oWriteData2Reg", 64'(bus.oWriteData2Reg), 64'(expData));
        checkVal("oStall",         64'(bus.oStall),         64'(loadPending));
        checkVal("oMemErr",        64'(bus.oMemErr),        64'(expErr));
        checkVal("oRetired",       64'(bus.oRetired),       64'(expRetired));
    endtask

    task automatic drive(input bit v, input bit [1:0] sig, input bit [31:0] alu, input bit [4:0] r,
                         input bit [31:0] md, input bit mdv, input bit fl, input bit rst);
        bus.iValid        = v;
        bus.iSig_WB       = sig;
        bus.iALUResult    = alu;
        bus.iWriteReg     = r;
        bus.iMemData      = md;
        bus.iMemDataValid = mdv;
        bus.iFlush        = fl;
        rstn              = rst;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 2'b00, 32'h0, 5'd0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        numChecks   = 0;
        numErrors   = 0;
        loadPending = 1'b0;
        expErr      = 1'b0;
        expRetired  = '0;

        // Reset: all outputs 0.
        drive(0, 2'b00, 32'h0, 5'd0, 32'h0, 0, 0, 1);
        drive(0, 2'b00, 32'h0, 5'd0, 32'h0, 0, 0, 1);
        idle(1);

        // R-type stream: three back-to-back writes, never stalled.
        stallCycles = 0;
        drive(1, 2'b01, 32'h11, 5'd8,  32'h0, 0, 0, 0);
        drive(1, 2'b01, 32'h22, 5'd9,  32'h0, 0, 0, 0);
        drive(1, 2'b01, 32'h33, 5'd10, 32'h0, 0, 0, 0);
        idle(1);
        checkVal("rtype_retired", 64'(bus.oRetired), 64'd3);
        checkVal("rtype_stall",   64'(stallCycles),  64'd0);

        // Load with data arriving on the third waiting cycle.
        stallCycles = 0;
        drive(1, 2'b11, 32'h100, 5'd5, 32'h0, 0, 0, 0);
        drive(1, 2'b11, 32'h100, 5'd5, 32'h0, 0, 0, 0);
        drive(1, 2'b11, 32'h100, 5'd5, 32'h0, 0, 0, 0);
        drive(1, 2'b11, 32'h100, 5'd5, 32'hDEADBEEF, 1, 0, 0);
        checkVal("load_stall_cycles", 64'(stallCycles),       64'd3);
        checkVal("load_data",         64'(bus.oWriteData2Reg), 64'hDEADBEEF);
        idle(1);

        // Load with data in the accept cycle: no stall.
        drive(1, 2'b11, 32'h0, 5'd7, 32'hCAFE0001, 1, 0, 0);
        idle(1);

        // Write to $0: data/address update, no enable, still retires.
        drive(1, 2'b01, 32'h1234, 5'd0, 32'h0, 0, 0, 0);
        checkVal("r0_data", 64'(bus.oWriteData2Reg), 64'h1234);
        idle(1);

        // Flush in WAIT with simultaneous data.
        drive(1, 2'b11, 32'h0, 5'd12, 32'h0, 0, 0, 0);
        drive(1, 2'b11, 32'h0, 5'd12, 32'h0, 0, 0, 0);
        drive(1, 2'b11, 32'h0, 5'd12, 32'h55AA55AA, 1, 1, 0);
        idle(2);

        // Timeout: no data ever; err sticks.
        stallCycles = 0;
        drive(1, 2'b11, 32'h0, 5'd13, 32'h0, 0, 0, 0);
        idle(MEM_TIMEOUT + 3);
        checkVal("timeout_stall_cycles", 64'(stallCycles), 64'(MEM_TIMEOUT));

        // Reset mid-WAIT, then a late data beat must not write.
        drive(1, 2'b11, 32'h0, 5'd14, 32'h0, 0, 0, 0);
        idle(2);
        drive(0, 2'b00, 32'h0, 5'd0, 32'h0, 0, 0, 1);
        drive(0, 2'b00, 32'h0, 5'd0, 32'h77777777, 1, 0, 0);
        idle(1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)),
                  $urandom,
                  5'($urandom_range(0, 31)),
                  $urandom,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
